// File: rtl/fifo_sync_param.sv
`default_nettype none
// ============================================================================
// Module   : fifo_sync_param
// Purpose  : Parametrised single-clock synchronous FIFO with registered read
//            data, registered full/empty/count status, an illegal-operation
//            flag and optional almost-full / almost-empty watermarks.
// Ports    : clk          - clock, all logic on posedge
//            rst_n        - synchronous active-low reset
//            wen / din    - write request and write data
//            ren / dout   - read request and registered read data
//            error        - high for one cycle after an illegal request
//            full / empty - registered occupancy flags
//            count        - registered occupancy, 0..DEPTH
//            almost_full  - count >= AF_LEVEL (watermark build only)
//            almost_empty - count <= AE_LEVEL (watermark build only)
// Options  : define FIFO_WATERMARK_EN to build the watermark flags; otherwise
//            both watermark outputs are tied low.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_sync_param #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 8,
  parameter int AW       = $clog2(DEPTH),
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wen,
  input  logic              ren,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              error,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       count,
  output logic              almost_full,
  output logic              almost_empty
);

  localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);
  localparam logic [AW:0]   CNT_ONE    = (AW+1)'(1);

  // Elaboration-time sanity: a non-power-of-two depth would break the natural
  // pointer rollover, and watermark levels beyond DEPTH could never toggle.
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) ||
      (AF_LEVEL > DEPTH) || (AE_LEVEL > DEPTH) || (AE_LEVEL < 0)) begin : g_bad_config
    bad_fifo_sync_param_configuration u_bad_config ();
  end

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [AW-1:0]     waddr_q, waddr_d;
  logic [AW-1:0]     raddr_q, raddr_d;
  logic [AW:0]       count_q, count_d;
  logic [DATA_W-1:0] dout_q,  dout_d;
  logic              error_q, error_d;
  logic              full_q,  full_d;
  logic              empty_q, empty_d;
  logic              rd_ok;
  logic              wr_ok;

  // Qualification uses the registered count only. A write into a full FIFO is
  // allowed when a read retires the oldest word in the same cycle.
  always_comb begin
    rd_ok   = ren & (count_q != '0);
    wr_ok   = wen & ((count_q != FULL_COUNT) | rd_ok);
    error_d = (ren & (count_q == '0)) | (wen & (count_q == FULL_COUNT) & ~ren);

    waddr_d = wr_ok ? (waddr_q + PTR_ONE) : waddr_q;
    raddr_d = rd_ok ? (raddr_q + PTR_ONE) : raddr_q;

    // The read slot is sampled from the pre-write memory, so a full FIFO with
    // simultaneous read+write returns the old word before it is overwritten.
    dout_d  = rd_ok ? mem_q[raddr_q] : '0;

    count_d = count_q;
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    full_d  = (count_d == FULL_COUNT);
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      waddr_q <= '0;
      raddr_q <= '0;
      count_q <= '0;
      dout_q  <= '0;
      error_q <= 1'b0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      waddr_q <= waddr_d;
      raddr_q <= raddr_d;
      count_q <= count_d;
      dout_q  <= dout_d;
      error_q <= error_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (rst_n && wr_ok) begin
      mem_q[waddr_q] <= din;
    end
  end

`ifdef FIFO_WATERMARK_EN
  localparam logic [AW:0] AF_COUNT = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] AE_COUNT = (AW+1)'(AE_LEVEL);

  logic almost_full_q,  almost_full_d;
  logic almost_empty_q, almost_empty_d;

  always_comb begin
    almost_full_d  = (count_d >= AF_COUNT);
    almost_empty_d = (count_d <= AE_COUNT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
    end else begin
      almost_full_q  <= almost_full_d;
      almost_empty_q <= almost_empty_d;
    end
  end

  assign almost_full  = almost_full_q;
  assign almost_empty = almost_empty_q;
`else
  assign almost_full  = 1'b0;
  assign almost_empty = 1'b0;
`endif

  assign dout  = dout_q;
  assign error = error_q;
  assign full  = full_q;
  assign empty = empty_q;
  assign count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_sync_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_sync_param
// Purpose  : Directed, table-driven bench for fifo_sync_param (DEPTH=8,
//            DATA_W=8) with hand-computed expected outputs, plus a
//            hand-written mid-burst reset sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_sync_param;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wen;
  logic       ren;
  logic [7:0] din;
  logic [7:0] dout;
  logic       error;
  logic       full;
  logic       empty;
  logic [3:0] count;
  logic       almost_full;
  logic       almost_empty;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rst_n;
    logic       wen;
    logic       ren;
    logic [7:0] din;
    logic [7:0] exp_dout;
    logic       exp_err;
    logic [3:0] exp_cnt;
  } vec_t;

  vec_t vecs[$];

  fifo_sync_param #(
    .DATA_W (8),
    .DEPTH  (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wen          (wen),
    .ren          (ren),
    .din          (din),
    .dout         (dout),
    .error        (error),
    .full         (full),
    .empty        (empty),
    .count        (count),
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
  );

  always #5 clk = ~clk;

  task automatic add(input logic r, input logic w, input logic rd, input logic [7:0] d,
                     input logic [7:0] q, input logic e, input int c);
    vec_t v;
    v.rst_n = r; v.wen = w; v.ren = rd; v.din = d;
    v.exp_dout = q; v.exp_err = e; v.exp_cnt = 4'(c);
    vecs.push_back(v);
  endtask

  task automatic chk1(input string tag, input int idx, input string sig,
                      input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] %s: got %h expected %h", tag, idx, sig, act, exp);
    end
  endtask

  // Full/empty and watermarks are derived from the expected count.
  task automatic check_all(input string tag, input int idx, input logic [7:0] e_dout,
                           input logic e_err, input logic [3:0] e_cnt);
    logic e_af, e_ae;
`ifdef FIFO_WATERMARK_EN
    e_af = (e_cnt >= 4'd6);
    e_ae = (e_cnt <= 4'd2);
`else
    e_af = 1'b0;
    e_ae = 1'b0;
`endif
    chk1(tag, idx, "dout",  dout, e_dout);
    chk1(tag, idx, "error", {7'd0, error}, {7'd0, e_err});
    chk1(tag, idx, "count", {4'd0, count}, {4'd0, e_cnt});
    chk1(tag, idx, "full",  {7'd0, full},  {7'd0, (e_cnt == 4'd8)});
    chk1(tag, idx, "empty", {7'd0, empty}, {7'd0, (e_cnt == 4'd0)});
    chk1(tag, idx, "almost_full",  {7'd0, almost_full},  {7'd0, e_af});
    chk1(tag, idx, "almost_empty", {7'd0, almost_empty}, {7'd0, e_ae});
  endtask

  task automatic step(input logic r, input logic w, input logic rd, input logic [7:0] d);
    rst_n = r; wen = w; ren = rd; din = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; wen = 1'b0; ren = 1'b0; din = 8'h00;

    // Reset.
    add(0, 0, 0, 8'h00, 8'h00, 0, 0);
    // Fill with 11..88.
    for (int i = 1; i <= 8; i++) add(1, 1, 0, 8'(i * 17), 8'h00, 0, i);
    // Write into full: dropped, error.
    add(1, 1, 0, 8'hFF, 8'h00, 1, 8);
    // Drain: 11..88, the rejected FF never appears; error clears.
    for (int i = 1; i <= 8; i++) add(1, 0, 1, 8'h00, 8'(i * 17), 0, 8 - i);
    // Read while empty, then idle clears error.
    add(1, 0, 1, 8'h00, 8'h00, 1, 0);
    add(1, 0, 0, 8'h00, 8'h00, 0, 0);
    // Empty with ren+wen: write accepted, error, dout 0.
    add(1, 1, 1, 8'hA1, 8'h00, 1, 1);
    add(1, 1, 0, 8'hA2, 8'h00, 0, 2);
    add(1, 1, 0, 8'hA3, 8'h00, 0, 3);
    // Steady count=3 with ren+wen for 5 cycles; write pointer wraps.
    add(1, 1, 1, 8'hB1, 8'hA1, 0, 3);
    add(1, 1, 1, 8'hB2, 8'hA2, 0, 3);
    add(1, 1, 1, 8'hB3, 8'hA3, 0, 3);
    add(1, 1, 1, 8'hB4, 8'hB1, 0, 3);
    add(1, 1, 1, 8'hB5, 8'hB2, 0, 3);
    // Drain across the read-pointer wrap.
    add(1, 0, 1, 8'h00, 8'hB3, 0, 2);
    add(1, 0, 1, 8'h00, 8'hB4, 0, 1);
    add(1, 0, 1, 8'h00, 8'hB5, 0, 0);
    // Fill with C1..C8 (watermarks toggle on the way up).
    for (int i = 1; i <= 8; i++) add(1, 1, 0, 8'(8'hC0 + i), 8'h00, 0, i);
    // Full with ren+wen: oldest word out, D1 stored, no error.
    add(1, 1, 1, 8'hD1, 8'hC1, 0, 8);
    // Drain: C2..C8 then D1.
    for (int i = 2; i <= 8; i++) add(1, 0, 1, 8'h00, 8'(8'hC0 + i), 0, 9 - i);
    add(1, 0, 1, 8'h00, 8'hD1, 0, 0);

    foreach (vecs[i]) begin
      step(vecs[i].rst_n, vecs[i].wen, vecs[i].ren, vecs[i].din);
      check_all("vec", i, vecs[i].exp_dout, vecs[i].exp_err, vecs[i].exp_cnt);
    end

    // Mid-burst reset: fill to 5, then raise an error condition is impossible
    // here, so assert reset together with wen+ren and confirm it wins.
    for (int i = 1; i <= 5; i++) begin
      step(1, 1, 0, 8'(8'hE0 + i));
      check_all("burst", i, 8'h00, 0, 4'(i));
    end
    step(1, 0, 1, 8'h00);
    check_all("burst_rd", 0, 8'hE1, 0, 4'd4);
    step(0, 1, 1, 8'h77);
    check_all("reset_mid", 0, 8'h00, 0, 4'd0);
    // Pointers restart at zero: the next write/read pair returns the new word.
    step(1, 1, 0, 8'h5A);
    check_all("post_rst_wr", 0, 8'h00, 0, 4'd1);
    step(1, 0, 1, 8'h00);
    check_all("post_rst_rd", 0, 8'h5A, 0, 4'd0);
    // Error pending at reset is cleared by reset.
    step(1, 0, 1, 8'h00);
    check_all("err_pre_rst", 0, 8'h00, 1, 4'd0);
    step(0, 0, 1, 8'h00);
    check_all("err_rst", 0, 8'h00, 0, 4'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
